gen1_tx_os_inserter: RTL and testbench

- Gen1 transmit stage directly upstream of the Gen1 scrambler.
- Accepts 32-bit link-layer data words over a valid/ready handshake and produces the per-word controls the scrambler consumes: data, datak, training_sequence, data_len and scramble_enable.
- Periodically inserts SKP ordered sets, and inserts TS1 ordered sets on request.
- When no data is offered, fills the lane with logical idle.

---
 rtl/gen1_tx_os_inserter.sv | 169 ++++++++++++++++
 tb/tb_gen1_tx_os_inserter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/gen1_tx_os_inserter.sv
// gen1_tx_os_inserter
//   Gen1 transmit stage feeding the Gen1 scrambler. Passes 32-bit link words
//   through a valid/ready handshake. Inserts a SKP ordered set every
//   SKP_INTERVAL output words. Inserts TS1 ordered sets (4 words each) while
//   ts1_req_i is high. Fills the lane with logical idle when nothing is offered.
//
// Ports
//   clk_i                in   clock
//   rst_i                in   synchronous active-high reset
//   in_data_i/_datak_i   in   link word and per-byte K flags (byte 0 = [7:0])
//   in_valid_i           in   input word valid
//   in_ready_o           out  high when the next output word will be DATA
//   ts1_req_i            in   level request for back-to-back TS1 sets
//   ts1_ctrl_i           in   TS1 training-control symbol (symbol 5)
//   data_o, datak_o      out  word and K flags to the scrambler
//   training_sequence_o  out  per-byte TS flag to the scrambler
//   data_len_o           out  constant 2'b10 (four bytes)
//   scramble_enable_o    out  low only on SKP words
//   skp_sent_o           out  one-cycle pulse per SKP word
//
// State table (the state names the word currently on the outputs)
//   state    | meaning
//   ST_DATA  | link data or logical idle word
//   ST_SKP   | SKP ordered set word
//   ST_TS1   | TS1 word, idx_q selects word 0..3
module gen1_tx_os_inserter #(
  parameter int         SKP_INTERVAL = 295,
  parameter logic [7:0] LINK_NUM     = 8'hF7,
  parameter logic [7:0] LANE_NUM     = 8'hF7,
  parameter logic [7:0] N_FTS        = 8'd16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] in_data_i,
  input  logic [3:0]  in_datak_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic        ts1_req_i,
  input  logic [7:0]  ts1_ctrl_i,
  output logic [31:0] data_o,
  output logic [3:0]  datak_o,
  output logic [3:0]  training_sequence_o,
  output logic [1:0]  data_len_o,
  output logic        scramble_enable_o,
  output logic        skp_sent_o
);

  localparam int CW = (SKP_INTERVAL > 2) ? $clog2(SKP_INTERVAL) : 1;
  localparam logic [CW-1:0] SKP_TC = CW'(SKP_INTERVAL - 1);

  localparam logic [7:0]  COM      = 8'hBC;
  localparam logic [7:0]  PAD      = 8'hF7;
  localparam logic [7:0]  TS1_ID   = 8'h4A;
  localparam logic [31:0] SKP_WORD = 32'h1C1C1CBC;

  typedef enum logic [1:0] {ST_DATA, ST_SKP, ST_TS1} state_t;

  state_t        state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [CW-1:0] skp_cnt_q, skp_cnt_d;
  logic          skp_pend_q, skp_pend_d;
  logic [7:0]    ctrl_q, ctrl_d;

  logic [31:0]   data_d;
  logic [3:0]    datak_d;
  logic [3:0]    ts_d;
  logic          scr_d;
  logic          skp_d;

  // State register and registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q             <= ST_DATA;
      idx_q               <= 2'd0;
      skp_cnt_q           <= '0;
      skp_pend_q          <= 1'b0;
      ctrl_q              <= 8'h00;
      data_o              <= 32'h0;
      datak_o             <= 4'h0;
      training_sequence_o <= 4'h0;
      data_len_o          <= 2'b10;
      scramble_enable_o   <= 1'b1;
      skp_sent_o          <= 1'b0;
    end else begin
      state_q             <= state_d;
      idx_q               <= idx_d;
      skp_cnt_q           <= skp_cnt_d;
      skp_pend_q          <= skp_pend_d;
      ctrl_q              <= ctrl_d;
      data_o              <= data_d;
      datak_o             <= datak_d;
      training_sequence_o <= ts_d;
      data_len_o          <= 2'b10;
      scramble_enable_o   <= scr_d;
      skp_sent_o          <= skp_d;
    end
  end

  // Next word selection: an open TS1 set finishes first, then a pending SKP,
  // then a new TS1 set, otherwise data/idle.
  always_comb begin
    state_d    = ST_DATA;
    idx_d      = 2'd0;
    skp_cnt_d  = skp_cnt_q;
    skp_pend_d = skp_pend_q;

    if (state_q == ST_TS1 && idx_q != 2'd3) begin
      state_d = ST_TS1;
      idx_d   = idx_q + 2'd1;
    end else if (skp_pend_q) begin
      state_d = ST_SKP;
    end else if (ts1_req_i) begin
      state_d = ST_TS1;
    end

    // SKP words do not advance the interval counter. An expiry while a SKP is
    // already pending just leaves the single pending flag set.
    if (state_d == ST_SKP) begin
      skp_pend_d = 1'b0;
    end else if (skp_cnt_q == SKP_TC) begin
      skp_cnt_d  = '0;
      skp_pend_d = 1'b1;
    end else begin
      skp_cnt_d = skp_cnt_q + 1'b1;
    end

    ctrl_d = (state_d == ST_TS1 && idx_d == 2'd0) ? ts1_ctrl_i : ctrl_q;
  end

  assign in_ready_o = !rst_i && (state_d == ST_DATA);

  // Content of the next word
  always_comb begin
    data_d  = 32'h0;
    datak_d = 4'h0;
    ts_d    = 4'h0;
    scr_d   = 1'b1;
    skp_d   = 1'b0;
    case (state_d)
      ST_DATA: begin
        if (in_valid_i && in_ready_o) begin
          data_d  = in_data_i;
          datak_d = in_datak_i;
        end
      end
      ST_SKP: begin
        data_d  = SKP_WORD;
        datak_d = 4'hF;
        scr_d   = 1'b0;
        skp_d   = 1'b1;
      end
      ST_TS1: begin
        ts_d = 4'hF;
        case (idx_d)
          2'd0: begin
            data_d  = {N_FTS, LANE_NUM, LINK_NUM, COM};
            // PAD link/lane symbols are K characters
            datak_d = {1'b0, LANE_NUM == PAD, LINK_NUM == PAD, 1'b1};
          end
          // word 1 uses the control symbol captured with word 0
          2'd1:    data_d = {TS1_ID, TS1_ID, ctrl_q, 8'h02};
          default: data_d = {TS1_ID, TS1_ID, TS1_ID, TS1_ID};
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_gen1_tx_os_inserter.sv
module tb_gen1_tx_os_inserter;

  localparam logic [31:0] SKPW = 32'h1C1C1CBC;
  localparam logic [31:0] T0W  = 32'h10F7F7BC;
  localparam logic [31:0] T2W  = 32'h4A4A4A4A;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] in_data_i;
  logic [3:0]  in_datak_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic        ts1_req_i;
  logic [7:0]  ts1_ctrl_i;
  logic [31:0] data_o;
  logic [3:0]  datak_o;
  logic [3:0]  training_sequence_o;
  logic [1:0]  data_len_o;
  logic        scramble_enable_o;
  logic        skp_sent_o;

  gen1_tx_os_inserter #(.SKP_INTERVAL(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .in_data_i(in_data_i), .in_datak_i(in_datak_i), .in_valid_i(in_valid_i),
    .in_ready_o(in_ready_o), .ts1_req_i(ts1_req_i), .ts1_ctrl_i(ts1_ctrl_i),
    .data_o(data_o), .datak_o(datak_o), .training_sequence_o(training_sequence_o),
    .data_len_o(data_len_o), .scramble_enable_o(scramble_enable_o),
    .skp_sent_o(skp_sent_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        rst;
    logic        valid;
    logic [31:0] din;
    logic [3:0]  dk;
    logic        req;
    logic [7:0]  ctrl;
    logic        rdy;
    logic [31:0] dout;
    logic [3:0]  dko;
    logic [3:0]  tso;
    logic        scr;
    logic        skp;
  } vec_t;

  vec_t vecs[18];

  function automatic vec_t mk(logic r, logic v, logic [31:0] d, logic [3:0] k,
                              logic q, logic [7:0] c, logic rdy, logic [31:0] o,
                              logic [3:0] ko, logic [3:0] t, logic s, logic p);
    vec_t x;
    x.rst = r; x.valid = v; x.din = d; x.dk = k; x.req = q; x.ctrl = c;
    x.rdy = rdy; x.dout = o; x.dko = ko; x.tso = t; x.scr = s; x.skp = p;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // drive inputs away from the active edge and let comb logic settle
  task automatic drive(input logic r, input logic v, input logic [31:0] d,
                       input logic [3:0] k, input logic q, input logic [7:0] c);
    @(negedge clk_i);
    rst_i = r; in_valid_i = v; in_data_i = d; in_datak_i = k;
    ts1_req_i = q; ts1_ctrl_i = c;
    #2;
  endtask

  task automatic edge_sample();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [43:0] pack_out();
    return {data_o, datak_o, training_sequence_o, scramble_enable_o, skp_sent_o, data_len_o};
  endfunction

  initial begin
    logic [31:0] exp_w[12];
    logic        exp_r[12];
    logic [31:0] q[$];
    logic [31:0] next_val;
    logic [31:0] exp_v;
    int          n_data;
    logic        hs;

    rst_i = 1'b1; in_valid_i = 1'b0; in_data_i = '0; in_datak_i = '0;
    ts1_req_i = 1'b0; ts1_ctrl_i = '0;

    vecs[0]  = mk(1, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 1, 0);
    vecs[1]  = mk(0, 0, 0, 0, 0, 8'h00, 1, 0, 0, 0, 1, 0);
    vecs[2]  = mk(0, 0, 0, 0, 0, 8'h00, 1, 0, 0, 0, 1, 0);
    vecs[3]  = mk(0, 0, 0, 0, 0, 8'h00, 1, 0, 0, 0, 1, 0);
    vecs[4]  = mk(0, 0, 0, 0, 0, 8'h00, 1, 0, 0, 0, 1, 0);
    vecs[5]  = mk(0, 0, 0, 0, 0, 8'h00, 0, SKPW, 4'hF, 0, 0, 1);
    vecs[6]  = mk(0, 0, 0, 0, 0, 8'h00, 1, 0, 0, 0, 1, 0);
    vecs[7]  = mk(0, 1, 32'h03020100, 0, 0, 8'h00, 1, 32'h03020100, 0, 0, 1, 0);
    vecs[8]  = mk(0, 1, 32'h11223344, 1, 0, 8'h00, 1, 32'h11223344, 1, 0, 1, 0);
    vecs[9]  = mk(0, 1, 32'h55667788, 0, 0, 8'h00, 1, 32'h55667788, 0, 0, 1, 0);
    vecs[10] = mk(0, 1, 32'h99AABBCC, 0, 0, 8'h00, 0, SKPW, 4'hF, 0, 0, 1);
    vecs[11] = mk(0, 1, 32'h99AABBCC, 0, 0, 8'h00, 1, 32'h99AABBCC, 0, 0, 1, 0);
    vecs[12] = mk(0, 0, 0, 0, 1, 8'h00, 0, T0W, 4'h7, 4'hF, 1, 0);
    vecs[13] = mk(0, 0, 0, 0, 0, 8'hFF, 0, 32'h4A4A0002, 0, 4'hF, 1, 0);
    vecs[14] = mk(0, 0, 0, 0, 0, 8'h00, 0, T2W, 0, 4'hF, 1, 0);
    vecs[15] = mk(0, 0, 0, 0, 0, 8'h00, 0, T2W, 0, 4'hF, 1, 0);
    vecs[16] = mk(0, 0, 0, 0, 0, 8'h00, 0, SKPW, 4'hF, 0, 0, 1);
    vecs[17] = mk(0, 0, 0, 0, 0, 8'h00, 1, 0, 0, 0, 1, 0);

    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].rst, vecs[i].valid, vecs[i].din, vecs[i].dk, vecs[i].req, vecs[i].ctrl);
      chk($sformatf("vec%0d_ready", i), 64'(in_ready_o), 64'(vecs[i].rdy));
      edge_sample();
      chk($sformatf("vec%0d_out", i), 64'(pack_out()),
          64'({vecs[i].dout, vecs[i].dko, vecs[i].tso, vecs[i].scr, vecs[i].skp, 2'b10}));
    end

    // SKP expiring inside a held TS1 request: set completes, one SKP, next set.
    exp_w = '{32'h0, 32'h0, T0W, 32'h4A4A5A02, T2W, T2W, SKPW,
              T0W, 32'h4A4A5A02, T2W, T2W, SKPW};
    exp_r = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    drive(1, 0, 0, 0, 0, 8'h00);
    edge_sample();
    for (int i = 0; i < 12; i++) begin
      drive(0, 0, 0, 0, i >= 2, 8'h5A);
      chk($sformatf("skp_in_ts1_ready%0d", i), 64'(in_ready_o), 64'(exp_r[i]));
      edge_sample();
      chk($sformatf("skp_in_ts1_word%0d", i), 64'({data_o, skp_sent_o}),
          64'({exp_w[i], exp_w[i] == SKPW}));
    end

    // Reset during TS1 word 2 aborts the set; counter restarts from 0.
    drive(1, 0, 0, 0, 0, 8'h00);
    edge_sample();
    drive(0, 0, 0, 0, 1, 8'h00);
    edge_sample();
    drive(0, 0, 0, 0, 0, 8'h00);
    edge_sample();
    drive(0, 0, 0, 0, 0, 8'h00);
    edge_sample();
    chk("rst_mid_ts1_word2", 64'(data_o), 64'(T2W));
    drive(1, 0, 0, 0, 0, 8'h00);
    chk("rst_ready_low", 64'(in_ready_o), 64'(0));
    edge_sample();
    chk("rst_mid_ts1_out", 64'(pack_out()), 64'({32'h0, 4'h0, 4'h0, 1'b1, 1'b0, 2'b10}));
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 0, 8'h00);
      edge_sample();
      chk($sformatf("post_rst_idle%0d", i), 64'(pack_out()),
          64'({32'h0, 4'h0, 4'h0, 1'b1, 1'b0, 2'b10}));
    end
    drive(0, 0, 0, 0, 0, 8'h00);
    edge_sample();
    chk("post_rst_first_skp", 64'({data_o, skp_sent_o}), 64'({SKPW, 1'b1}));

    // Streaming scoreboard: incrementing data, periodic SKP, TS1 bursts.
    drive(1, 0, 0, 0, 0, 8'h00);
    edge_sample();
    next_val = 32'h0000_1000;
    n_data = 0;
    for (int c = 0; c < 60; c++) begin
      drive(0, 1, next_val, 0, (c == 10 || c == 11 || c == 30), 8'h00);
      hs = in_ready_o;
      if (hs) begin
        q.push_back(next_val);
        next_val = next_val + 1;
      end
      edge_sample();
      if (!skp_sent_o && training_sequence_o == 4'h0) begin
        exp_v = (q.size() > 0) ? q.pop_front() : 32'hDEAD_BEEF;
        chk($sformatf("stream_word%0d", c), 64'({data_o, datak_o}), 64'({exp_v, 4'h0}));
        n_data++;
      end
    end
    chk("stream_queue_drained", 64'(q.size()), 64'(0));
    chk("stream_enough_data", 64'(n_data >= 35), 64'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
